// File: rtl/census_match.sv
// census_match: picks the best disparity for each left census string against a sliding window
// of past right census strings. Two stages: hamming costs per disparity, then masked argmin.
module census_match #(
  parameter int unsigned CENSUS_WIDTH = 8,
  parameter int unsigned MAX_DISP     = 16,
  parameter int unsigned DISP_BITS    = 4,
  parameter int unsigned COST_BITS    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    line_start,
  input  logic [CENSUS_WIDTH-1:0] left_census,
  input  logic [CENSUS_WIDTH-1:0] right_census,
  output logic                    out_valid,
  output logic [DISP_BITS-1:0]    disparity,
  output logic [COST_BITS-1:0]    min_cost
);

  localparam logic [DISP_BITS-1:0] FillMax = DISP_BITS'(MAX_DISP - 1);

  logic [CENSUS_WIDTH-1:0] rwin_q [MAX_DISP-1];
  logic [DISP_BITS-1:0]    fill_q, fill_d;
  logic [CENSUS_WIDTH-1:0] cand [MAX_DISP];
  logic [COST_BITS-1:0]    cost_d [MAX_DISP];
  logic [COST_BITS-1:0]    cost_q [MAX_DISP];
  logic [MAX_DISP-1:0]     mask_d, mask_q;
  logic                    s1_valid_q;
  logic [COST_BITS-1:0]    best_cost, eff_cost;
  logic [DISP_BITS-1:0]    best_disp;
  logic                    out_valid_q;
  logic [DISP_BITS-1:0]    disparity_q;
  logic [COST_BITS-1:0]    min_cost_q;

  function automatic logic [COST_BITS-1:0] popcount(input logic [CENSUS_WIDTH-1:0] v);
    logic [COST_BITS-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < CENSUS_WIDTH; i++) begin
      n = n + COST_BITS'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    cand[0] = right_census;
    for (int unsigned d = 1; d < MAX_DISP; d++) begin
      cand[d] = rwin_q[d-1];
    end
    for (int unsigned d = 0; d < MAX_DISP; d++) begin
      cost_d[d] = popcount(left_census ^ cand[d]);
      // A line start masks the stale window without clearing it.
      mask_d[d] = (d == 0) || (!line_start && (DISP_BITS'(d) <= fill_q));
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (in_valid) begin
      if (line_start)            fill_d = DISP_BITS'(1);
      else if (fill_q != FillMax) fill_d = fill_q + 1'b1;
    end else if (line_start) begin
      fill_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < MAX_DISP - 1; k++) rwin_q[k] <= '0;
      fill_q <= '0;
    end else begin
      if (in_valid) begin
        rwin_q[0] <= right_census;
        for (int unsigned k = 1; k < MAX_DISP - 1; k++) rwin_q[k] <= rwin_q[k-1];
      end
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned d = 0; d < MAX_DISP; d++) cost_q[d] <= '0;
      mask_q     <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      for (int unsigned d = 0; d < MAX_DISP; d++) cost_q[d] <= cost_d[d];
      mask_q     <= mask_d;
      s1_valid_q <= in_valid;
    end
  end

  // Masked candidates carry an all-ones cost; strict '<' keeps the smallest d on ties.
  always_comb begin
    best_cost = cost_q[0];
    best_disp = '0;
    eff_cost  = '1;
    for (int unsigned d = 1; d < MAX_DISP; d++) begin
      eff_cost = mask_q[d] ? cost_q[d] : '1;
      if (eff_cost < best_cost) begin
        best_cost = eff_cost;
        best_disp = DISP_BITS'(d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      disparity_q <= '0;
      min_cost_q  <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        disparity_q <= best_disp;
        min_cost_q  <= best_cost;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign disparity = disparity_q;
  assign min_cost  = min_cost_q;

endmodule

// File: tb/tb_census_match.sv
// Bench for census_match: directed scenarios plus random traffic checked every cycle against a
// row-history model of the disparity search.
module tb_census_match;

  localparam int MaxDisp = 16;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       line_start;
  logic [7:0] left_census;
  logic [7:0] right_census;
  logic       out_valid;
  logic [3:0] disparity;
  logic [3:0] min_cost;

  int checks = 0;
  int errors = 0;

  census_match #(
    .CENSUS_WIDTH(8),
    .MAX_DISP    (16),
    .DISP_BITS   (4),
    .COST_BITS   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .line_start  (line_start),
    .left_census (left_census),
    .right_census(right_census),
    .out_valid   (out_valid),
    .disparity   (disparity),
    .min_cost    (min_cost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation attached to the sample currently on the inputs (-1 = none).
  int cur_ld = -1;
  int cur_lc = -1;

  // Model: right strings seen since the last line start, newest first, at most MaxDisp-1 kept.
  logic [7:0] row_hist[$];
  bit st_v, ex_v;
  int st_d, st_c, st_ld, st_lc;
  int ex_d, ex_c, ex_ld, ex_lc;
  int best_c, best_d, c;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_hist.delete();
      st_v = 0; ex_v = 0; ex_d = 0; ex_c = 0; ex_ld = -1; ex_lc = -1;
    end else begin
      ex_v = st_v;
      if (st_v) begin
        ex_d = st_d; ex_c = st_c; ex_ld = st_ld; ex_lc = st_lc;
      end else begin
        ex_ld = -1; ex_lc = -1;
      end
      st_v = 0;
      if (in_valid) begin
        if (line_start) row_hist.delete();
        best_c = $countones(left_census ^ right_census);
        best_d = 0;
        foreach (row_hist[i]) begin
          c = $countones(left_census ^ row_hist[i]);
          if (c < best_c) begin
            best_c = c;
            best_d = i + 1;
          end
        end
        st_v = 1; st_d = best_d; st_c = best_c; st_ld = cur_ld; st_lc = cur_lc;
        row_hist.push_front(right_census);
        if (row_hist.size() > MaxDisp - 1) void'(row_hist.pop_back());
      end else if (line_start) begin
        row_hist.delete();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("out_valid", out_valid, ex_v);
    chk("disparity", disparity, ex_d);
    chk("min_cost", min_cost, ex_c);
    if (ex_v && ex_ld >= 0) begin
      chk("lit_disparity", disparity, ex_ld);
      chk("lit_min_cost", min_cost, ex_lc);
    end
  end

  task automatic drive(input bit v, input bit ls, input logic [7:0] l, input logic [7:0] r,
                       input int ld, input int lc);
    @(negedge clk);
    in_valid = v; line_start = ls; left_census = l; right_census = r;
    cur_ld = ld; cur_lc = lc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 8'h00, -1, -1);
  endtask

  logic [7:0] rt[24];
  logic [7:0] one;

  initial begin
    reset = 1'b0; in_valid = 1'b1; line_start = 1'b0;
    left_census = 8'h5A; right_census = 8'hA5;

    // Reset held with in_valid asserted: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_disparity", disparity, 0);
      chk("rst_min_cost", min_cost, 0);
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;

    // Identical left/right: always disparity 0, cost 0.
    for (int k = 0; k < 20; k++) drive(1, k == 0, 8'(k), 8'(k), 0, 0);
    idle(3);

    // Shifted pattern: left matches the right string 5 samples back.
    one = 8'h01;
    for (int t = 0; t < 24; t++) rt[t] = (one << (t % 8)) ^ 8'(t);
    for (int t = 0; t < 24; t++) begin
      if (t >= 5) drive(1, t == 0, rt[t-5], rt[t], 5, 0);
      else        drive(1, t == 0, 8'($urandom), rt[t], -1, -1);
    end
    idle(3);

    // All candidates tie at cost 0: smallest disparity wins.
    for (int i = 0; i < 20; i++) drive(1, 0, 8'h0F, 8'h0F, 0, 0);
    idle(3);

    // Line start masks a window full of perfect matches.
    for (int i = 0; i < 20; i++) drive(1, 0, 8'($urandom), 8'hFF, -1, -1);
    drive(1, 1, 8'hFF, 8'h00, 0, 8);
    idle(3);

    // Reset with results in flight, then only d=0 is a candidate.
    for (int i = 0; i < 15; i++) drive(1, 0, 8'($urandom), 8'h00, -1, -1);
    @(posedge clk); #3;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_flight_out_valid", out_valid, 0);
    chk("rst_flight_disparity", disparity, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    drive(1, 0, 8'h00, 8'hFF, 0, 8);
    idle(3);

    // Random traffic with a narrow value space to provoke ties, plus occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] msk;
      msk = ($urandom_range(0, 1) == 0) ? 8'h33 : 8'hFF;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            8'($urandom) & msk, 8'($urandom) & msk, -1, -1);
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
